// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter that shares one iterative shift-add multiplier core
// between NUM_REQ requesters, with valid/ready handshakes on both sides.

module Multiplier #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    Clk,
  input  logic                    Start,
  input  logic [DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   B,
  output logic [2*DATA_WIDTH-1:0] Product,
  output logic                    Ready
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [CW-1:0]           count;
  logic [2*DATA_WIDTH-1:0] mcand;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0]   mplier;

  // No reset: an arbitrary power-up count still runs down to zero, so Ready
  // always rises within 2^CW cycles.
  always_ff @(posedge Clk) begin
    if (Start && count == '0) begin
      mcand  <= {{DATA_WIDTH{1'b0}}, A};
      mplier <= B;
      acc    <= '0;
      count  <= CW'(DATA_WIDTH);
    end else if (count != '0) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - 1'b1;
    end
  end

  assign Ready   = (count == '0);
  assign Product = acc;
endmodule

module multiplier_arbiter #(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_REQ    = 4,
  localparam int GW         = $clog2(NUM_REQ)
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            ReqValid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqA,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqB,
  output logic [NUM_REQ-1:0]            ReqReady,
  output logic [NUM_REQ-1:0]            RespValid,
  input  logic [NUM_REQ-1:0]            RespReady,
  output logic [2*DATA_WIDTH-1:0]       RespProduct,
  output logic [GW-1:0]                 GrantId,
  output logic                          Busy
);
  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t                  state;
  logic [GW-1:0]           ptr;
  logic [DATA_WIDTH-1:0]   op_a;
  logic [DATA_WIDTH-1:0]   op_b;
  logic                    core_start;
  logic                    core_ready;
  logic [2*DATA_WIDTH-1:0] core_product;

  logic                    grant_found;
  logic [GW-1:0]           grant_idx;
  logic [GW:0]             cand;
  logic                    accept;

  // Rotating priority scan starting at ptr; the first valid index wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (GW+1)'(k);
      if (cand >= (GW+1)'(NUM_REQ)) cand = cand - (GW+1)'(NUM_REQ);
      if (!grant_found && ReqValid[cand[GW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[GW-1:0];
      end
    end
  end

  assign accept     = (state == S_IDLE) && grant_found && !Reset;
  assign ReqReady   = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  assign RespValid  = (state == S_RESP && !Reset) ? (NUM_REQ'(1) << GrantId) : '0;
  assign core_start = (state == S_ISSUE) && !Reset;
  assign Busy       = (state != S_IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_DRAIN;
      ptr         <= '0;
      GrantId     <= '0;
      op_a        <= '0;
      op_b        <= '0;
      RespProduct <= '0;
    end else begin
      case (state)
        S_DRAIN: if (core_ready) state <= S_IDLE;
        S_IDLE: begin
          if (grant_found) begin
            op_a    <= ReqA[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            op_b    <= ReqB[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            GrantId <= grant_idx;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_BUSY;
        S_BUSY: begin
          if (core_ready) begin
            RespProduct <= core_product;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (RespReady[GrantId]) begin
            ptr   <= (GrantId == GW'(NUM_REQ - 1)) ? '0 : GrantId + 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_DRAIN;
      endcase
    end
  end

  Multiplier #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .Clk     (Clk),
    .Start   (core_start),
    .A       (op_a),
    .B       (op_b),
    .Product (core_product),
    .Ready   (core_ready)
  );
endmodule
